timer_apb_responder: RTL and testbench

TIMER_APB_RESPONDER -- requirements
Module: timer_apb_responder

---
 rtl/timer_apb_responder.sv | 174 +++++++++++++++++
 tb/tb_timer_apb_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_apb_responder.sv
// timer_apb_responder: APB register front end for a timer core.
// Registers: TDR (data), TCR (control), TSR (sticky OVF/UDF status).
// Each access runs SETUP, WAIT_CYCLES wait states, then ACCESS (pready).
// Optional macro TIMER_APB_SLVERR_EN enables error responses for
// out-of-map addresses and for writes that set TSR bits to 1.

module timer_apb_responder #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    input  logic       ovf_evt_i,
    input  logic       udf_evt_i,
    output logic [7:0] tdr_o,
    output logic       load_o,
    output logic       updown_o,
    output logic       en_o,
    output logic [1:0] cks_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        WAIT   = 2'd2,
        ACCESS = 2'd3
    } state_t;

    localparam logic [1:0] WAIT_LAST = 2'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
    localparam logic [7:0] TCR_MASK  = 8'hB3;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] wait_cnt_q;
    logic [7:0] addr_q;
    logic       wr_q;
    logic [7:0] wdata_q;
    logic [7:0] tdr_q;
    logic [7:0] tcr_q;
    logic [1:0] tsr_q;
    logic [1:0] tsr_clr;
    logic       wr_en;
    logic [7:0] rd_data;

    // FSM state register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; losing psel before ACCESS abandons the transfer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (WAIT_CYCLES > 0) begin
                    state_d = WAIT;
                end else begin
                    state_d = ACCESS;
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Wait-state counter, cleared whenever the FSM is not waiting
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wait_cnt_q <= 2'd0;
        end else if (state_q == WAIT) begin
            wait_cnt_q <= wait_cnt_q + 2'd1;
        end else begin
            wait_cnt_q <= 2'd0;
        end
    end

    // Latch address, direction and data on entry to SETUP so later bus
    // changes inside the transfer cannot disturb it
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            addr_q  <= 8'h00;
            wr_q    <= 1'b0;
            wdata_q <= 8'h00;
        end else if (state_q == IDLE && psel && !penable) begin
            addr_q  <= paddr;
            wr_q    <= pwrite;
            wdata_q <= pwdata;
        end
    end

    assign wr_en   = (state_q == ACCESS) && wr_q;
    assign tsr_clr = (wr_en && addr_q == 8'h02) ? ~wdata_q[1:0] : 2'b00;

    // TDR and TCR commit on the ACCESS edge; TCR keeps only implemented bits
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tdr_q <= 8'h00;
            tcr_q <= 8'h00;
        end else if (wr_en) begin
            if (addr_q == 8'h00) begin
                tdr_q <= wdata_q;
            end
            if (addr_q == 8'h01) begin
                tcr_q <= wdata_q & TCR_MASK;
            end
        end
    end

    // Sticky status flags: an event in the same cycle as a clear wins
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tsr_q <= 2'b00;
        end else begin
            tsr_q <= {udf_evt_i, ovf_evt_i} | (tsr_q & ~tsr_clr);
        end
    end

    // Read mux; TSR comes from the register so a coincident event is not seen yet
    always_comb begin
        rd_data = 8'h00;
        case (addr_q)
            8'h00:   rd_data = tdr_q;
            8'h01:   rd_data = tcr_q;
            8'h02:   rd_data = {6'b0, tsr_q};
            default: rd_data = 8'h00;
        endcase
    end

    assign pready = (state_q == ACCESS);
    assign prdata = (pready && !wr_q) ? rd_data : 8'h00;

`ifdef TIMER_APB_SLVERR_EN
    assign pslverr = pready && ((addr_q > 8'h02) ||
                                (wr_q && addr_q == 8'h02 && wdata_q != 8'h00));
`else
    assign pslverr = 1'b0;
`endif

    assign tdr_o    = tdr_q;
    assign load_o   = tcr_q[7];
    assign updown_o = tcr_q[5];
    assign en_o     = tcr_q[4];
    assign cks_o    = tcr_q[1:0];

endmodule

// File: tb/tb_timer_apb_responder.sv
// tb_timer_apb_responder: table-driven bench for timer_apb_responder with
// the default WAIT_CYCLES=1, plus directed multi-cycle sequences.

module tb_timer_apb_responder;

`ifdef TIMER_APB_SLVERR_EN
    localparam bit SLVERR_ON = 1'b1;
`else
    localparam bit SLVERR_ON = 1'b0;
`endif
    localparam int EXP_LAT = 3;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic       ovf_evt_i;
    logic       udf_evt_i;
    logic [7:0] tdr_o;
    logic       load_o;
    logic       updown_o;
    logic       en_o;
    logic [1:0] cks_o;

    int pass_count  = 0;
    int check_count = 0;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic [7:0] exp_tdr;
        logic [7:0] exp_tcr;
    } vec_t;

    vec_t vecs[15];

    timer_apb_responder dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .ovf_evt_i (ovf_evt_i),
        .udf_evt_i (udf_evt_i),
        .tdr_o     (tdr_o),
        .load_o    (load_o),
        .updown_o  (updown_o),
        .en_o      (en_o),
        .cks_o     (cks_o)
    );

    // Free-running clock
    always #5 pclk = ~pclk;

    // Overall time bound
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] ctrlPack();
        return {load_o, 1'b0, updown_o, en_o, 2'b00, cks_o};
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
        end
    endtask

    // One APB transfer; evt is driven onto {udf,ovf} during the pready cycle,
    // corrupt scrambles the bus right after the setup edge
    task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                                 input logic [1:0] evt, input bit corrupt,
                                 output logic [7:0] rdata, output logic err, output int lat);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        lat = 0; rdata = 8'h00; err = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge pclk);
            if (i == 1) begin
                penable = 1'b1;
                if (corrupt) begin
                    paddr  = 8'h01;
                    pwdata = 8'hEE;
                    pwrite = ~wr;
                end
            end
            if (pready) begin
                lat = i;
                rdata = prdata;
                err = pslverr;
                ovf_evt_i = evt[0];
                udf_evt_i = evt[1];
                break;
            end
        end
        @(posedge pclk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        ovf_evt_i = 1'b0; udf_evt_i = 1'b0;
    endtask

    task automatic checkedXfer(input string name, input logic wr, input logic [7:0] addr,
                               input logic [7:0] wdata, input logic [7:0] exp_rd,
                               input logic [1:0] evt, input bit corrupt);
        logic [7:0] rd;
        logic       err;
        int         lat;
        logic       exp_err;
        applyStimulus(wr, addr, wdata, evt, corrupt, rd, err, lat);
        exp_err = SLVERR_ON && ((addr > 8'h02) || (wr && addr == 8'h02 && wdata != 8'h00));
        checkOutput({name, " latency"}, 8'(lat), 8'(EXP_LAT));
        checkOutput({name, " prdata"}, rd, exp_rd);
        checkOutput({name, " pslverr"}, {7'b0, err}, {7'b0, exp_err});
    endtask

    task automatic pulseEvent(input logic [1:0] evt);
        @(negedge pclk);
        ovf_evt_i = evt[0]; udf_evt_i = evt[1];
        @(negedge pclk);
        ovf_evt_i = 1'b0; udf_evt_i = 1'b0;
    endtask

    initial begin
        logic seen_ready;

        //           wr    addr   wdata  rdata  tdr    tcr
        vecs[0]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 8'h00, 8'hA5, 8'h00, 8'hA5, 8'h00};
        vecs[2]  = '{1'b0, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'h00};
        vecs[3]  = '{1'b1, 8'h01, 8'hFF, 8'h00, 8'hA5, 8'hB3};
        vecs[4]  = '{1'b0, 8'h01, 8'h00, 8'hB3, 8'hA5, 8'hB3};
        vecs[5]  = '{1'b0, 8'h02, 8'h00, 8'h00, 8'hA5, 8'hB3};
        vecs[6]  = '{1'b0, 8'h05, 8'h00, 8'h00, 8'hA5, 8'hB3};
        vecs[7]  = '{1'b1, 8'h05, 8'h77, 8'h00, 8'hA5, 8'hB3};
        vecs[8]  = '{1'b0, 8'h03, 8'h00, 8'h00, 8'hA5, 8'hB3};
        vecs[9]  = '{1'b1, 8'h01, 8'h4C, 8'h00, 8'hA5, 8'h00};
        vecs[10] = '{1'b0, 8'h01, 8'h00, 8'h00, 8'hA5, 8'h00};
        vecs[11] = '{1'b1, 8'h01, 8'h21, 8'h00, 8'hA5, 8'h21};
        vecs[12] = '{1'b0, 8'h01, 8'h00, 8'h21, 8'hA5, 8'h21};
        vecs[13] = '{1'b1, 8'h00, 8'h5A, 8'h00, 8'h5A, 8'h21};
        vecs[14] = '{1'b0, 8'h00, 8'h00, 8'h5A, 8'h5A, 8'h21};

        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 8'h00; ovf_evt_i = 1'b0; udf_evt_i = 1'b0;

        repeat (2) @(negedge pclk);
        checkOutput("reset pready", {7'b0, pready}, 8'h00);
        checkOutput("reset prdata", prdata, 8'h00);
        checkOutput("reset pslverr", {7'b0, pslverr}, 8'h00);
        checkOutput("reset tdr_o", tdr_o, 8'h00);
        checkOutput("reset ctrl", ctrlPack(), 8'h00);
        presetn = 1'b1;

        $display("[TB] table vectors");
        for (int i = 0; i < 15; i++) begin
            checkedXfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                        vecs[i].exp_rdata, 2'b00, 1'b0);
            checkOutput($sformatf("vec%0d tdr_o", i), tdr_o, vecs[i].exp_tdr);
            checkOutput($sformatf("vec%0d ctrl", i), ctrlPack(), vecs[i].exp_tcr);
        end

        $display("[TB] status flag sequences");
        pulseEvent(2'b01);
        repeat (3) @(negedge pclk);
        checkedXfer("tsr ovf set", 1'b0, 8'h02, 8'h00, 8'h01, 2'b00, 1'b0);
        checkedXfer("tsr read pre-event", 1'b0, 8'h02, 8'h00, 8'h01, 2'b10, 1'b0);
        checkedXfer("tsr both set", 1'b0, 8'h02, 8'h00, 8'h03, 2'b00, 1'b0);
        checkedXfer("tsr clear ovf wr", 1'b1, 8'h02, 8'h02, 8'h00, 2'b00, 1'b0);
        checkedXfer("tsr after ovf clear", 1'b0, 8'h02, 8'h00, 8'h02, 2'b00, 1'b0);
        checkedXfer("tsr write ones", 1'b1, 8'h02, 8'hFF, 8'h00, 2'b00, 1'b0);
        checkedXfer("tsr ones no change", 1'b0, 8'h02, 8'h00, 8'h02, 2'b00, 1'b0);
        checkedXfer("tsr clear vs udf wr", 1'b1, 8'h02, 8'h00, 8'h00, 2'b10, 1'b0);
        checkedXfer("tsr set wins", 1'b0, 8'h02, 8'h00, 8'h02, 2'b00, 1'b0);
        checkedXfer("tsr clear all wr", 1'b1, 8'h02, 8'h00, 8'h00, 2'b00, 1'b0);
        checkedXfer("tsr cleared", 1'b0, 8'h02, 8'h00, 8'h00, 2'b00, 1'b0);

        $display("[TB] bus changes after setup");
        checkedXfer("capture wr", 1'b1, 8'h00, 8'h11, 8'h00, 2'b00, 1'b1);
        checkOutput("capture tdr_o", tdr_o, 8'h11);
        checkOutput("capture ctrl", ctrlPack(), 8'h21);

        $display("[TB] aborted transfers");
        seen_ready = 1'b0;
        for (int stage = 1; stage <= 2; stage++) begin
            @(negedge pclk);
            psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h99;
            for (int c = 1; c <= 5; c++) begin
                @(negedge pclk);
                if (pready) seen_ready = 1'b1;
                if (c == 1) penable = 1'b1;
                if (c == stage) begin
                    psel = 1'b0; penable = 1'b0;
                end
            end
        end
        checkOutput("abort pready", {7'b0, seen_ready}, 8'h00);
        checkOutput("abort tdr_o", tdr_o, 8'h11);

        $display("[TB] reset during wait state");
        pulseEvent(2'b01);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h3C;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        presetn = 1'b0;
        #1;
        checkOutput("midreset pready", {7'b0, pready}, 8'h00);
        checkOutput("midreset prdata", prdata, 8'h00);
        checkOutput("midreset tdr_o", tdr_o, 8'h00);
        checkOutput("midreset ctrl", ctrlPack(), 8'h00);
        ovf_evt_i = 1'b1; udf_evt_i = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        ovf_evt_i = 1'b0; udf_evt_i = 1'b0;
        psel = 1'b0; penable = 1'b0;
        presetn = 1'b1;
        seen_ready = 1'b0;
        repeat (3) begin
            @(negedge pclk);
            if (pready) seen_ready = 1'b1;
        end
        checkOutput("postreset pready", {7'b0, seen_ready}, 8'h00);
        checkOutput("postreset tdr_o", tdr_o, 8'h00);
        checkedXfer("postreset tdr read", 1'b0, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0);
        checkedXfer("postreset tsr read", 1'b0, 8'h02, 8'h00, 8'h00, 2'b00, 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
